// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
// Shared constants and types for the 4x3 matrix keypad scanner.
//   KEY_W / ROWS / COLS : keypad geometry (12 keys = 4 rows x 3 columns)
//   KEY_1 .. KEY_HASH   : one-hot key codes, bit index = row*COLS + col
//   scan_state_t        : column-scan FSM states
//   is_onehot()         : true when exactly one bit of a key vector is set
// -----------------------------------------------------------------------------
package keypad_pkg;

    localparam int unsigned KEY_W = 12;
    localparam int unsigned ROWS  = 4;
    localparam int unsigned COLS  = 3;

    localparam logic [KEY_W-1:0] KEY_1    = 12'h001;
    localparam logic [KEY_W-1:0] KEY_2    = 12'h002;
    localparam logic [KEY_W-1:0] KEY_3    = 12'h004;
    localparam logic [KEY_W-1:0] KEY_4    = 12'h008;
    localparam logic [KEY_W-1:0] KEY_5    = 12'h010;
    localparam logic [KEY_W-1:0] KEY_6    = 12'h020;
    localparam logic [KEY_W-1:0] KEY_7    = 12'h040;
    localparam logic [KEY_W-1:0] KEY_8    = 12'h080;
    localparam logic [KEY_W-1:0] KEY_9    = 12'h100;
    localparam logic [KEY_W-1:0] KEY_STAR = 12'h200;
    localparam logic [KEY_W-1:0] KEY_0    = 12'h400;
    localparam logic [KEY_W-1:0] KEY_HASH = 12'h800;

    typedef enum logic [1:0] {
        COL0 = 2'd0,
        COL1 = 2'd1,
        COL2 = 2'd2
    } scan_state_t;

    // Clearing the lowest set bit leaves zero only for a single-bit vector.
    function automatic logic is_onehot(input logic [KEY_W-1:0] v);
        return (v != 12'h000) && ((v & (v - 12'h001)) == 12'h000);
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// -----------------------------------------------------------------------------
// keypad_debounce
// Frame-rate debouncer for the keypad scanner. A candidate key vector must be
// seen on DEBOUNCE_FRAMES consecutive frames before it is published.
// Optional auto-repeat of key_pulse_o when KEYPAD_AUTOREPEAT_EN is defined.
// Ports:
//   clk          in   system clock
//   rst          in   synchronous reset, active-high
//   frame_done_i in   one-cycle strobe marking a complete keypad frame
//   cand_i       in   frame candidate (one-hot key or zero), valid with strobe
//   key_data_o   out  debounced one-hot key, zero = no key
//   key_pulse_o  out  one-cycle strobe when key_data_o takes a new nonzero value
// -----------------------------------------------------------------------------
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_FRAMES = 4,
    parameter int unsigned REPEAT_FRAMES   = 50
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_done_i,
    input  logic [KEY_W-1:0] cand_i,
    output logic [KEY_W-1:0] key_data_o,
    output logic             key_pulse_o
);

    localparam logic [3:0] DB_MAX = 4'(DEBOUNCE_FRAMES);

    logic [KEY_W-1:0] prev_q, prev_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [KEY_W-1:0] data_q, data_d;
    logic             pulse_q, pulse_d;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int unsigned        REP_W    = (REPEAT_FRAMES < 2) ? 1 : $clog2(REPEAT_FRAMES);
    localparam logic [REP_W-1:0]   REP_LAST = REP_W'(REPEAT_FRAMES - 1);
    localparam logic [REP_W-1:0]   REP_ONE  = REP_W'(1);
    logic [REP_W-1:0] rep_q, rep_d;
`endif

    // Next-state: stability count, publish decision and pulse generation.
    always_comb begin
        prev_d  = prev_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        pulse_d = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_d   = rep_q;
`endif
        if (frame_done_i) begin
            if (cand_i == prev_q) begin
                if (cnt_q >= DB_MAX) begin
                    cnt_d = DB_MAX;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end else begin
                // A differing frame restarts the run with itself as first frame.
                cnt_d  = 4'd1;
                prev_d = cand_i;
            end

            if ((cnt_d == DB_MAX) && (cand_i != data_q)) begin
                data_d  = cand_i;
                pulse_d = (cand_i != 12'h000);
`ifdef KEYPAD_AUTOREPEAT_EN
                rep_d   = '0;
`endif
            end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
                // Repeat period is counted in frames from the last pulse.
                if (data_q != 12'h000) begin
                    if (rep_q == REP_LAST) begin
                        rep_d   = '0;
                        pulse_d = 1'b1;
                    end else begin
                        rep_d   = rep_q + REP_ONE;
                    end
                end else begin
                    rep_d = '0;
                end
`else
                data_d = data_q;
`endif
            end
        end else begin
            pulse_d = 1'b0;
        end
    end

    // Debounce state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q  <= 12'h000;
            cnt_q   <= 4'd0;
            data_q  <= 12'h000;
            pulse_q <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_q   <= '0;
`endif
        end else begin
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            pulse_q <= pulse_d;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_q   <= rep_d;
`endif
        end
    end

    assign key_data_o  = data_q;
    assign key_pulse_o = pulse_q;

endmodule

// File: rtl/keypad_scan.sv
// -----------------------------------------------------------------------------
// keypad_scan
// Scans a 4-row x 3-column matrix keypad, synchronises the row returns,
// assembles one 12-bit frame per full column sweep and debounces it into a
// one-hot key_data bus (bit = row*3 + col) with a key_pulse press strobe.
// Optional build macro: KEYPAD_AUTOREPEAT_EN (auto-repeat of key_pulse).
// Ports:
//   clk        in   system clock
//   rst        in   synchronous reset, active-high
//   key_row    in   row returns, active-high, asynchronous to clk
//   key_col    out  one-hot column drive, active-high
//   key_data   out  debounced one-hot key, zero = no key
//   key_pulse  out  one-cycle strobe on each new nonzero key_data value
// -----------------------------------------------------------------------------
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV        = 24999,
    parameter int unsigned DEBOUNCE_FRAMES = 4,
    parameter int unsigned REPEAT_FRAMES   = 50
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ROWS-1:0]   key_row,
    output logic [COLS-1:0]   key_col,
    output logic [KEY_W-1:0]  key_data,
    output logic              key_pulse
);

    localparam int unsigned      DIV_W   = $clog2(SCAN_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

    logic [ROWS-1:0]  row_meta_q;
    logic [ROWS-1:0]  row_s_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_s;
    scan_state_t      state_q, state_d;
    logic [COLS-1:0]  col_q, col_d;
    logic [KEY_W-1:0] acc_q, acc_d;
    logic             frame_done_s;
    logic [KEY_W-1:0] cand_s;

    // Two-flop synchroniser for the asynchronous row returns.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta_q <= 4'h0;
            row_s_q    <= 4'h0;
        end else begin
            row_meta_q <= key_row;
            row_s_q    <= row_meta_q;
        end
    end

    // Sampling happens on the last dwell cycle so the rows have settled.
    assign tick_s       = (div_q == DIV_MAX);
    assign frame_done_s = tick_s && (state_q == COL2);

    // Divider next value, scan FSM next state and column drive decode.
    always_comb begin
        if (tick_s) begin
            div_d = '0;
        end else begin
            div_d = div_q + DIV_ONE;
        end

        state_d = state_q;
        if (tick_s) begin
            case (state_q)
                COL0:    state_d = COL1;
                COL1:    state_d = COL2;
                COL2:    state_d = COL0;
                default: state_d = COL0;
            endcase
        end else begin
            state_d = state_q;
        end

        case (state_d)
            COL0:    col_d = 3'b001;
            COL1:    col_d = 3'b010;
            COL2:    col_d = 3'b100;
            default: col_d = 3'b001;
        endcase
    end

    // Frame accumulator: the driven column's bits of each row are overwritten
    // with the synchronised returns, so no explicit clear between frames.
    always_comb begin
        acc_d = acc_q;
        if (tick_s) begin
            for (int r = 0; r < ROWS; r++) begin
                acc_d[r*COLS +: COLS] = (acc_q[r*COLS +: COLS] & ~col_q)
                                      | ({COLS{row_s_q[r]}} & col_q);
            end
        end else begin
            acc_d = acc_q;
        end
        // Ghosting and multi-press both collapse to "no key".
        if (is_onehot(acc_d)) begin
            cand_s = acc_d;
        end else begin
            cand_s = 12'h000;
        end
    end

    // Scan state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q   <= '0;
            state_q <= COL0;
            col_q   <= 3'b001;
            acc_q   <= 12'h000;
        end else begin
            div_q   <= div_d;
            state_q <= state_d;
            col_q   <= col_d;
            acc_q   <= acc_d;
        end
    end

    keypad_debounce #(
        .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES),
        .REPEAT_FRAMES   (REPEAT_FRAMES)
    ) u_debounce (
        .clk          (clk),
        .rst          (rst),
        .frame_done_i (frame_done_s),
        .cand_i       (cand_s),
        .key_data_o   (key_data),
        .key_pulse_o  (key_pulse)
    );

    assign key_col = col_q;

endmodule

// File: tb/tb_keypad_scan.sv
module tb_keypad_scan;
    import keypad_pkg::*;

    localparam int SD    = 3;
    localparam int DF    = 2;
    localparam int RF    = 100;   // long enough that no scenario sees a repeat
    localparam int FRAME = 3 * (SD + 1);
    localparam int BUDGET = 3 * FRAME + 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  key_row;
    logic [2:0]  key_col;
    logic [11:0] key_data;
    logic        key_pulse;
    logic [11:0] keys = 12'h000;   // pressed keys of the simulated matrix

    int checks   = 0;
    int failures = 0;
    int pulse_cnt = 0;
    int lat;
    int pc0;

    logic [12:0] exp_q[$];          // {pulse, key_data} expected per change
    logic [12:0] mon_e;
    logic [11:0] mon_prev = 12'h000;

    keypad_scan #(
        .SCAN_DIV        (SD),
        .DEBOUNCE_FRAMES (DF),
        .REPEAT_FRAMES   (RF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_row   (key_row),
        .key_col   (key_col),
        .key_data  (key_data),
        .key_pulse (key_pulse)
    );

    always #5 clk = ~clk;

    // Matrix model: a row reads high when a pressed key sits in a driven column.
    always_comb begin
        key_row = 4'h0;
        for (int r = 0; r < 4; r++) begin
            key_row[r] = |(keys[r*3 +: 3] & key_col);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic expect_evt(input logic pulse, input logic [11:0] data);
        exp_q.push_back({pulse, data});
    endtask

    task automatic wait_drain(input string tag, input int budget, output int cycles);
        cycles = 0;
        while (exp_q.size() != 0 && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        check_eq(tag, exp_q.size(), 0);
    endtask

    // Scoreboard: every key_data change is matched against the next expected event.
    always @(posedge clk) begin
        #1;
        if (key_pulse === 1'b1) pulse_cnt++;
        if (rst) begin
            mon_prev = 12'h000;
        end else if (key_data !== mon_prev) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_key_data", key_data, mon_prev);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("key_data", key_data, mon_e[11:0]);
                check_eq("key_pulse", key_pulse, mon_e[12]);
            end
            mon_prev = key_data;
        end else if (key_pulse !== 1'b0) begin
            check_eq("stray_pulse", key_pulse, 1'b0);
        end
    end

    initial begin
        // Reset and column sweep
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_col", key_col, 3'b001);
        check_eq("rst_data", key_data, 12'h000);
        check_eq("rst_pulse", key_pulse, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 13; i++) begin
            check_eq("col_seq", key_col,
                     ((i % 12) < 4) ? 3'b001 : ((i % 12) < 8) ? 3'b010 : 3'b100);
            @(negedge clk);
        end

        // Press '1', hold ~6 frames, release
        pc0 = pulse_cnt;
        keys = KEY_1;
        expect_evt(1'b1, 12'h001);
        wait_drain("press1_latency", BUDGET, lat);
        repeat (6 * FRAME - lat) @(negedge clk);
        check_eq("press1_pulses", pulse_cnt - pc0, 1);
        keys = 12'h000;
        expect_evt(1'b0, 12'h000);
        wait_drain("release1_latency", BUDGET, lat);
        check_eq("release1_pulses", pulse_cnt - pc0, 1);

        // '#' then direct change to '0'
        pc0 = pulse_cnt;
        keys = KEY_HASH;
        expect_evt(1'b1, 12'h800);
        wait_drain("hash_latency", BUDGET, lat);
        repeat (FRAME) @(negedge clk);
        keys = KEY_0;
        expect_evt(1'b1, 12'h400);
        wait_drain("zero_latency", BUDGET, lat);
        check_eq("hash_zero_pulses", pulse_cnt - pc0, 2);
        keys = 12'h000;
        expect_evt(1'b0, 12'h000);
        wait_drain("release0_latency", BUDGET, lat);

        // Two keys together never publish
        pc0 = pulse_cnt;
        keys = KEY_1 | KEY_5;
        repeat (10 * FRAME) @(negedge clk);
        check_eq("multi_data", key_data, 12'h000);
        check_eq("multi_pulses", pulse_cnt - pc0, 0);
        keys = 12'h000;
        repeat (3 * FRAME) @(negedge clk);

        // Bounce '5' on alternate frames, then hold
        pc0 = pulse_cnt;
        for (int f = 0; f < 8; f++) begin
            keys = (f % 2 == 0) ? KEY_5 : 12'h000;
            repeat (FRAME) @(negedge clk);
        end
        check_eq("bounce_data", key_data, 12'h000);
        keys = KEY_5;
        expect_evt(1'b1, 12'h010);
        wait_drain("bounce_settle", BUDGET, lat);
        check_eq("bounce_pulses", pulse_cnt - pc0, 1);
        keys = 12'h000;
        expect_evt(1'b0, 12'h000);
        wait_drain("release5_latency", BUDGET, lat);

        // Reset mid-press, then re-acquire
        keys = KEY_1;
        expect_evt(1'b1, 12'h001);
        wait_drain("pre_reset_press", BUDGET, lat);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_data", key_data, 12'h000);
        check_eq("midrst_pulse", key_pulse, 1'b0);
        check_eq("midrst_col", key_col, 3'b001);
        rst = 1'b0;
        pc0 = pulse_cnt;
        expect_evt(1'b1, 12'h001);
        wait_drain("reacq_drain", BUDGET, lat);
        check_eq("reacq_latency", lat, 2 * FRAME);
        repeat (2 * FRAME) @(negedge clk);
        check_eq("reacq_pulses", pulse_cnt - pc0, 1);
        keys = 12'h000;
        expect_evt(1'b0, 12'h000);
        wait_drain("release_final", BUDGET, lat);

        repeat (2 * FRAME) @(negedge clk);
        check_eq("queue_empty", exp_q.size(), 0);
        check_eq("final_data", key_data, 12'h000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
Upstream input stage for the menu and game state blocks. It scans a 4-row x 3-column matrix keypad and synchronises and debounces the row returns. It publishes the result as the 12-bit one-hot key_data bus those blocks decode, e.g. 12'b0000_0000_0001 = key '1'. It also emits a one-cycle key_pulse on each new press for edge-triggered consumers.

Parameters:
SCAN_DIV, 24999, column dwell is SCAN_DIV+1 clk cycles. Tick fires when the divider reaches SCAN_DIV.
DEBOUNCE_FRAMES, 4, consecutive identical full-keypad frames required before key_data updates (range 1..15).
REPEAT_FRAMES, 50, auto-repeat period in frames. Used only with KEYPAD_AUTOREPEAT_EN.

Ports:
clk  in  1  system clock, the single clock of the block.
rst  in  1  synchronous reset, active-high.
key_row  in  4  row returns. Active-high when a key in the driven column is pressed. Asynchronous to clk.
key_col  out  3  column drive, one-hot, active-high.
key_data  out  12  debounced one-hot key. Bit index = row*3+col. bit0='1' ... bit8='9', bit9='*', bit10='0', bit11='#'. All-zero = no key.
key_pulse  out  1  single-cycle strobe when key_data changes to a nonzero value.

Behaviour:
- Reset (rst=1 at a clk edge): key_col=3'b001, key_data=0, key_pulse=0. Divider, column index, frame accumulator, stable counter and synchroniser flops all clear. Reset mid-scan or mid-press aborts the scan and restarts from column 0.
- Synchroniser: key_row passes through 2 flops (row_s) before any use.
- Divider: counts 0..SCAN_DIV. On reaching SCAN_DIV, tick=1 for one cycle and the count returns to 0.
- Scan FSM has states COL0, COL1, COL2. On tick:
  - row_s is captured into the accumulator at bits {row*3+col} for the current column.
  - The state advances COL0->COL1->COL2->COL0.
  - key_col follows the state (001, 010, 100) and updates in the same cycle as the state.
  - Sampling on the last cycle of the dwell gives rows SCAN_DIV cycles to settle. SCAN_DIV must be >= 3.
- Frame complete = tick in COL2. The candidate is the accumulated 12-bit vector if it has exactly one bit set. Zero bits or two or more bits (ghosting or multi-press) give candidate 0.
- Debounce, evaluated once per frame:
  - If candidate equals the previous candidate, stable_cnt increments, saturating at DEBOUNCE_FRAMES. Otherwise stable_cnt resets to 1 and the previous candidate is replaced.
  - When stable_cnt reaches DEBOUNCE_FRAMES and candidate differs from key_data, key_data <= candidate on the cycle after frame completion.
- key_pulse=1 for exactly the cycle key_data takes a new nonzero value. It is 0 on release (to 0) and 0 while held. A direct key-to-key change (A to B with no zero frame in between) pulses.
- Latency: a press stable from the start of a frame appears on key_data after DEBOUNCE_FRAMES frames plus 1 cycle. A press starting mid-frame can take one extra frame. Frame = 3*(SCAN_DIV+1) cycles.
- Release follows the same debounce path with candidate 0.

Optional Feature:
KEYPAD_AUTOREPEAT_EN:
- Defined: while key_data is nonzero and unchanged, key_pulse re-fires every REPEAT_FRAMES frames, counted from the initial pulse. A repeat counter is cleared on any key_data change or on reset.
- Undefined: no repeat logic. key_pulse fires once per press.

Decomposition:
- Package keypad_pkg holds:
  - KEY_W=12, ROWS=4, COLS=3.
  - Localparams KEY_1..KEY_9, KEY_STAR, KEY_0, KEY_HASH as 12-bit one-hot constants.
  - Enum scan_state_t {COL0, COL1, COL2}.
- One sub-module, keypad_debounce: frame candidate in, frame_done strobe in, key_data and key_pulse out. It holds stable_cnt and, if enabled, the repeat logic.
- Scan FSM, divider and synchroniser stay in keypad_scan.

Test Plan:
All scenarios use SCAN_DIV=3, DEBOUNCE_FRAMES=2 (frame = 12 cycles).
- Reset: hold rst 2 cycles -> key_col=001, key_data=0, key_pulse=0. Then key_col=001 for 4 cycles, 010 for 4, 100 for 4, back to 001.
- Press '1' (key_row[0]=1 whenever key_col=001), held 6 frames -> key_data=12'h001 within 3 frames, key_pulse high exactly 1 cycle. Release -> key_data=0 within 3 frames, no pulse.
- Press '#' (key_row[3]=1 when key_col=100) -> key_data=12'h800, one pulse. Switch directly to '0' (key_row[3] with col 010) -> key_data=12'h400, second pulse.
- Press '1' and '5' together -> key_data stays 0 and no pulse for 10 frames.
- Bounce '5' (row1/col1) on alternate frames for 8 frames -> key_data stays 0. Then hold steady -> 12'h010 with one pulse.
- Assert rst mid-press with key_data=12'h001 -> key_data=0 next cycle. Press still held -> re-acquired after 2-3 frames with one new pulse. With KEYPAD_AUTOREPEAT_EN and REPEAT_FRAMES=3, holding '1' for 10 frames -> pulses at frames 0, 3, 6, 9 after acquisition.
